// File: rtl/spi_flash_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_pkg
// Description : Opcodes, field widths and state encoding shared by the SPI
//               flash read-path responder.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam int CMD_BITS        = 8;
  localparam int ADDR_FIELD_BITS = 24;
  localparam int DUMMY_BITS      = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DUMMY  = 3'd3,
    DATA   = 3'd4,
    IGNORE = 3'd5
  } state_t;

  // True when the counter holds the index of the final bit of a field.
  function automatic logic is_last(input logic [4:0] cnt, input int bits);
    return cnt == 5'(bits - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_flash_responder_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : Multi-stage synchronizer with rise/fall event outputs, used
//               for the SPI clock.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_din,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_pipe;
  logic              r_prev;
  logic              w_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pipe <= '0;
      r_prev <= 1'b0;
    end else begin
      r_pipe[0] <= i_din;
      for (int i = 1; i < STAGES; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
      r_prev <= w_sync;
    end
  end

  assign w_sync = r_pipe[STAGES-1];
  assign o_rise = w_sync & ~r_prev;
  assign o_fall = ~w_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_responder
// Description : SPI mode-0 target emulating a serial flash READ path; streams
//               bytes from a byte-wide memory port with auto-increment.
//               Optional FAST_READ (0x0B) under SPI_FLASH_RESPONDER_FAST_READ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int ADDR_BITS   = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spi_select,
  input  logic                 spi_clk,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd,
  input  logic [7:0]           mem_data,
  output logic                 busy
);

`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  localparam bit c_FAST_EN = 1'b1;
`else
  localparam bit c_FAST_EN = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] r_sel_pipe;
  logic [SYNC_STAGES-1:0] r_mosi_pipe;
  logic                   w_sel;
  logic                   w_mosi;
  logic                   w_rise;
  logic                   w_fall;

  state_t                 r_state;
  state_t                 w_next;
  logic [4:0]             r_bit_cnt;
  logic [7:0]             r_rx_shift;
  logic [7:0]             r_tx_shift;
  logic [7:0]             r_prefetch;
  logic [ADDR_BITS-1:0]   r_addr;
  logic                   r_fast;
  logic                   r_rd_q;
  logic                   r_miso;
  logic                   r_mem_rd;
  logic [ADDR_BITS-1:0]   r_mem_addr;

  logic [7:0]             w_opcode;
  logic [ADDR_BITS-1:0]   w_addr_shift;
  logic                   w_cmd_accept;
  logic                   w_cmd_fast;
  logic                   w_cmd_done;
  logic                   w_addr_bit;
  logic                   w_cnt_step;
  logic                   w_issue_rd;
  logic [ADDR_BITS-1:0]   w_rd_addr;
  logic                   w_load_byte;
  logic                   w_shift_byte;
  logic                   w_oe;

  // Select idles high so the block comes out of reset deselected.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel_pipe  <= '1;
      r_mosi_pipe <= '0;
    end else begin
      r_sel_pipe[0]  <= spi_select;
      r_mosi_pipe[0] <= spi_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sel_pipe[i]  <= r_sel_pipe[i-1];
        r_mosi_pipe[i] <= r_mosi_pipe[i-1];
      end
    end
  end

  assign w_sel  = r_sel_pipe[SYNC_STAGES-1];
  assign w_mosi = r_mosi_pipe[SYNC_STAGES-1];

  spi_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_din  (spi_clk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_opcode     = {r_rx_shift[6:0], w_mosi};
  assign w_addr_shift = {r_addr[ADDR_BITS-2:0], w_mosi};
  assign w_cmd_fast   = c_FAST_EN && (w_opcode == CMD_FAST_READ);
  assign w_cmd_accept = (w_opcode == CMD_READ) || w_cmd_fast;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Deselect wins over any clock edge seen in the same cycle.
  always_comb begin
    w_next = r_state;
    if (w_sel) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:  w_next = CMD;
        CMD: begin
          if (w_rise && is_last(r_bit_cnt, CMD_BITS)) begin
            w_next = w_cmd_accept ? ADDR : IGNORE;
          end
        end
        ADDR: begin
          if (w_rise && is_last(r_bit_cnt, ADDR_FIELD_BITS)) begin
            w_next = r_fast ? DUMMY : DATA;
          end
        end
        DUMMY: begin
          if (w_rise && is_last(r_bit_cnt, DUMMY_BITS)) begin
            w_next = DATA;
          end
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_cmd_done   = 1'b0;
    w_addr_bit   = 1'b0;
    w_cnt_step   = 1'b0;
    w_issue_rd   = 1'b0;
    w_rd_addr    = r_addr;
    w_load_byte  = 1'b0;
    w_shift_byte = 1'b0;
    w_oe         = 1'b0;
    if (!w_sel) begin
      case (r_state)
        CMD: begin
          w_cnt_step = w_rise;
          w_cmd_done = w_rise && is_last(r_bit_cnt, CMD_BITS);
        end
        ADDR: begin
          w_cnt_step = w_rise;
          w_addr_bit = w_rise;
          if (w_rise && is_last(r_bit_cnt, ADDR_FIELD_BITS) && !r_fast) begin
            w_issue_rd = 1'b1;
            w_rd_addr  = w_addr_shift;
          end
        end
        DUMMY: begin
          w_cnt_step = w_rise;
          w_issue_rd = w_rise && is_last(r_bit_cnt, DUMMY_BITS);
        end
        DATA: begin
          w_oe       = 1'b1;
          w_cnt_step = w_fall;
          if (w_fall) begin
            if (r_bit_cnt == 5'd0) begin
              w_load_byte = 1'b1;
              w_issue_rd  = 1'b1;
            end else begin
              w_shift_byte = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_prefetch <= '0;
      r_addr     <= '0;
      r_fast     <= 1'b0;
      r_rd_q     <= 1'b0;
      r_miso     <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_mem_rd <= w_issue_rd;
      r_rd_q   <= r_mem_rd;
      // Memory answers one cycle after the strobe is seen.
      if (r_rd_q) begin
        r_prefetch <= mem_data;
      end

      if (w_next != r_state) begin
        r_bit_cnt <= '0;
      end else if (w_cnt_step) begin
        r_bit_cnt <= (r_state == DATA && r_bit_cnt == 5'd7) ? 5'd0 : r_bit_cnt + 5'd1;
      end

      if (r_state == CMD && w_cnt_step) begin
        r_rx_shift <= w_opcode;
      end

      if (r_state == IDLE) begin
        r_fast <= 1'b0;
      end else if (w_cmd_done) begin
        r_fast <= w_cmd_fast;
      end

      if (w_issue_rd) begin
        r_mem_addr <= w_rd_addr;
        r_addr     <= w_rd_addr + 1'b1;
      end else if (w_addr_bit) begin
        r_addr <= w_addr_shift;
      end

      if (w_load_byte) begin
        r_tx_shift <= r_prefetch;
        r_miso     <= r_prefetch[7];
      end else if (w_shift_byte) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        r_miso     <= r_tx_shift[6];
      end else if (w_next == IDLE) begin
        r_miso <= 1'b0;
      end
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = w_oe;
  assign mem_rd      = r_mem_rd;
  assign mem_addr    = r_mem_addr;
  assign busy        = ~w_sel;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_responder
// Description : Randomized self-checking bench for spi_flash_responder against
//               a transaction-level flash read model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_responder;

  localparam int HALF = 5;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_select = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [23:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] rd_log[$];

  always #5 clk = ~clk;

  spi_flash_responder #(
    .ADDR_BITS   (24),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_select  (spi_select),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .busy        (busy)
  );

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // Memory port: data valid the cycle after the strobe; every strobe logged.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_data <= mem_byte(mem_addr);
      rd_log.push_back(mem_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sel_low();
    spi_select = 1'b0;
    tick(4);
  endtask

  task automatic sel_high();
    spi_select = 1'b1;
    tick(HALF);
    spi_clk = 1'b0;
    tick(HALF);
  endtask

  // Mode 0: drive MOSI while the clock is low, sample MISO just before rising.
  task automatic xfer(input logic [7:0] tx, input int nbits,
                      output logic [7:0] rx, output logic oe_any);
    rx     = '0;
    oe_any = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_clk  = 1'b0;
      spi_mosi = tx[7-i];
      tick(HALF);
      rx     = {rx[6:0], spi_miso};
      oe_any = oe_any | spi_miso_oe;
      spi_clk = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic do_read(input string tag, input logic [7:0] op,
                         input logic [23:0] addr, input int nbytes);
    logic [7:0]  rx;
    logic        oe;
    logic        hdr_oe;
    logic        accept;
    logic        dummy;
    logic [23:0] a;
    int          base;
    accept = (op == 8'h03) || (FAST && op == 8'h0B);
    dummy  = (op == 8'h0B);
    base   = rd_log.size();
    hdr_oe = 1'b0;
    sel_low();
    check({tag, ".busy"}, busy, 1);
    xfer(op, 8, rx, oe);          hdr_oe = hdr_oe | oe;
    xfer(addr[23:16], 8, rx, oe); hdr_oe = hdr_oe | oe;
    xfer(addr[15:8], 8, rx, oe);  hdr_oe = hdr_oe | oe;
    xfer(addr[7:0], 8, rx, oe);   hdr_oe = hdr_oe | oe;
    if (dummy) begin
      xfer(8'($urandom), 8, rx, oe);
      hdr_oe = hdr_oe | oe;
    end
    check({tag, ".hdr_oe"}, hdr_oe, 0);
    for (int k = 0; k < nbytes; k++) begin
      a = addr + 24'(k);
      xfer(8'($urandom), 8, rx, oe);
      check({tag, ".oe"}, oe, accept);
      if (accept) check({tag, ".miso"}, rx, mem_byte(a));
    end
    sel_high();
    check({tag, ".oe_off"}, spi_miso_oe, 0);
    check({tag, ".busy_off"}, busy, 0);
    check({tag, ".nrd"}, rd_log.size() - base, accept ? nbytes + 1 : 0);
    if (accept) begin
      for (int k = 0; k <= nbytes; k++) begin
        if (base + k < rd_log.size()) begin
          a = addr + 24'(k);
          check({tag, ".rd_addr"}, rd_log[base + k], a);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0]  rx;
    logic        oe;
    logic [7:0]  op;
    logic [23:0] addr;
    int          base;

    tick(3);
    check("rst.miso", spi_miso, 0);
    check("rst.oe", spi_miso_oe, 0);
    check("rst.mem_rd", mem_rd, 0);
    check("rst.mem_addr", mem_addr, 0);
    check("rst.busy", busy, 0);
    rst_n = 1'b1;
    tick(3);

    do_read("rd10", 8'h03, 24'h000010, 1);
    do_read("rd100", 8'h03, 24'h000100, 4);
    do_read("wrap", 8'h03, 24'hFFFFFF, 2);
    do_read("ign9f", 8'h9F, 24'h123456, 1);
    do_read("rd20", 8'h03, 24'h000020, 1);

    // Abort mid-address, then a clean read must be unaffected.
    base = rd_log.size();
    sel_low();
    xfer(8'h03, 8, rx, oe);
    xfer(8'h12, 8, rx, oe);
    xfer(8'h34, 4, rx, oe);
    sel_high();
    check("abort.nrd", rd_log.size() - base, 0);
    check("abort.oe", spi_miso_oe, 0);
    do_read("rd01", 8'h03, 24'h000001, 1);

    do_read("fast", 8'h0B, 24'h000003, 1);

    // Reset in the middle of a data byte.
    sel_low();
    xfer(8'h03, 8, rx, oe);
    xfer(8'h00, 8, rx, oe);
    xfer(8'h00, 8, rx, oe);
    xfer(8'h40, 8, rx, oe);
    xfer(8'h00, 3, rx, oe);
    check("mid.oe", oe, 1);
    check("mid.bits", rx[2:0], mem_byte(24'h000040) >> 5);
    rst_n = 1'b0;
    tick(1);
    check("rstmid.miso", spi_miso, 0);
    check("rstmid.oe", spi_miso_oe, 0);
    check("rstmid.mem_rd", mem_rd, 0);
    check("rstmid.mem_addr", mem_addr, 0);
    check("rstmid.busy", busy, 0);
    spi_select = 1'b1;
    spi_clk    = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(4);

    for (int t = 0; t < 10; t++) begin
      case ($urandom_range(0, 5))
        0:       op = 8'h0B;
        1:       op = 8'($urandom);
        default: op = 8'h03;
      endcase
      addr = 24'($urandom);
      if (t % 3 == 0) addr = 24'hFFFFFF - 24'($urandom_range(0, 2));
      do_read("rand", op, addr, $urandom_range(1, 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
